// File: rtl/counter_modn.sv
// -----------------------------------------------------------------------------
// counter_modn
//   Parametrised modulo-N up/down counter. The count q always stays in the
//   range 0..MODULUS-1. tc is a combinational terminal-count flag meant to
//   drive the enable of the next cascaded stage. wrap is a registered
//   one-cycle pulse that follows every wrap-around edge.
//
// Configuration macro:
//   COUNTER_MODN_LOAD_EN - when defined, adds the load/din parallel-load
//                          ports. Priority is then clr > load > en.
//                          When undefined, priority is clr > en.
//
// Parameters:
//   WIDTH   - counter register width in bits
//   MODULUS - count range, legal 2 <= MODULUS <= 2**WIDTH
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset (q = 0, wrap = 0)
//   en    in   count enable
//   up    in   direction, 1 = increment, 0 = decrement
//   clr   in   synchronous clear to 0, highest priority
//   load  in   synchronous parallel load (COUNTER_MODN_LOAD_EN only)
//   din   in   load value, clamped to MODULUS-1 (COUNTER_MODN_LOAD_EN only)
//   q     out  current count, registered
//   tc    out  terminal count, combinational from q, en and up
//   wrap  out  registered pulse, high for the cycle after a wrap edge
// -----------------------------------------------------------------------------
module counter_modn #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 9
) (
  input  logic             clk,
  input  logic             rst,
`ifdef COUNTER_MODN_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] din,
`endif
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_r;
  logic             wrap_r;
  logic [WIDTH-1:0] count_next;
  logic             wrap_next;
  logic             at_max;
  logic             at_zero;

`ifdef COUNTER_MODN_LOAD_EN
  logic [WIDTH-1:0] load_val;
  logic             din_in_range;

  // Out-of-range load values clamp to the top of the count range.
  always_comb begin
    // Compare one bit wider so MODULUS = 2**WIDTH is representable.
    din_in_range = ({1'b0, din} < (WIDTH + 1)'(MODULUS));
    if (din_in_range) begin
      load_val = din;
    end else begin
      load_val = MAX_VAL;
    end
  end
`endif

  // Boundary detection shared by tc and the next-state logic.
  always_comb begin
    at_max  = (count_r == MAX_VAL);
    at_zero = (count_r == ZERO);
  end

  // Next-state: one action per edge with priority clr > load > en > hold.
  always_comb begin
    count_next = count_r;
    wrap_next  = 1'b0;
    if (clr) begin
      count_next = ZERO;
    end
`ifdef COUNTER_MODN_LOAD_EN
    else if (load) begin
      count_next = load_val;
    end
`endif
    else if (en) begin
      if (up) begin
        if (at_max) begin
          count_next = ZERO;
          wrap_next  = 1'b1;
        end else begin
          count_next = count_r + ONE;
        end
      end else begin
        if (at_zero) begin
          count_next = MAX_VAL;
          wrap_next  = 1'b1;
        end else begin
          count_next = count_r - ONE;
        end
      end
    end else begin
      count_next = count_r;
    end
  end

  // State register; reset clears any pending wrap pulse immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= ZERO;
      wrap_r  <= 1'b0;
    end else begin
      count_r <= count_next;
      wrap_r  <= wrap_next;
    end
  end

  // Terminal count deliberately ignores clr/load: a cascaded stage handles
  // its own clear/load, and gating here would add a path through them.
  always_comb begin
    if (up) begin
      tc = en & at_max;
    end else begin
      tc = en & at_zero;
    end
  end

  assign q    = count_r;
  assign wrap = wrap_r;

endmodule

// File: tb/tb_counter_modn.sv
// -----------------------------------------------------------------------------
// tb_counter_modn
//   Directed self-checking bench for counter_modn: a WIDTH 4 / MODULUS 9
//   instance under direct control, plus a cascaded MODULUS 9 -> MODULUS 4
//   pair. Load behaviour is exercised only when COUNTER_MODN_LOAD_EN is set.
// -----------------------------------------------------------------------------
module tb_counter_modn;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       clr;
  logic [3:0] q;
  logic       tc;
  logic       wrap;
`ifdef COUNTER_MODN_LOAD_EN
  logic       load;
  logic [3:0] din;
`endif

  // cascade pair
  logic       c_en;
  logic       c_clr;
  logic [3:0] lo_q;
  logic       lo_tc;
  logic       lo_wrap;
  logic [1:0] hi_q;
  logic       hi_tc;
  logic       hi_wrap;

  int total;
  int bad;

  counter_modn #(.WIDTH(4), .MODULUS(9)) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef COUNTER_MODN_LOAD_EN
    .load (load),
    .din  (din),
`endif
    .en   (en),
    .up   (up),
    .clr  (clr),
    .q    (q),
    .tc   (tc),
    .wrap (wrap)
  );

  counter_modn #(.WIDTH(4), .MODULUS(9)) u_lo (
    .clk  (clk),
    .rst  (rst),
`ifdef COUNTER_MODN_LOAD_EN
    .load (1'b0),
    .din  (4'd0),
`endif
    .en   (c_en),
    .up   (1'b1),
    .clr  (c_clr),
    .q    (lo_q),
    .tc   (lo_tc),
    .wrap (lo_wrap)
  );

  counter_modn #(.WIDTH(2), .MODULUS(4)) u_hi (
    .clk  (clk),
    .rst  (rst),
`ifdef COUNTER_MODN_LOAD_EN
    .load (1'b0),
    .din  (2'd0),
`endif
    .en   (lo_tc),
    .up   (1'b1),
    .clr  (c_clr),
    .q    (hi_q),
    .tc   (hi_tc),
    .wrap (hi_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0;
    c_en = 1'b0; c_clr = 1'b0;
`ifdef COUNTER_MODN_LOAD_EN
    load = 1'b0; din = 4'd0;
`endif
    #3;
    total++; if (q !== 4'd0) begin bad++; $display("FAIL reset_q got=%0d want=0", q); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b want=0", wrap); end
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL reset_tc got=%b want=0", tc); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    total++; if (q !== 4'd0) begin bad++; $display("FAIL reset_hold_q got=%0d want=0", q); end
  endtask

  task automatic test_count_up();
    int m;
    m = 0;
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      #1;
      total++; if (tc !== (m == 8)) begin bad++; $display("FAIL up_tc edge=%0d got=%b want=%b", i, tc, (m == 8)); end
      tick();
      total++; if (wrap !== (m == 8)) begin bad++; $display("FAIL up_wrap edge=%0d got=%b want=%b", i, wrap, (m == 8)); end
      m = (m == 8) ? 0 : m + 1;
      total++; if (q !== 4'(m)) begin bad++; $display("FAIL up_q edge=%0d got=%0d want=%0d", i, q, m); end
    end
  endtask

  task automatic test_count_down();
    int m;
    clr = 1'b1; tick(); clr = 1'b0;
    total++; if (q !== 4'd0) begin bad++; $display("FAIL down_clr_q got=%0d want=0", q); end
    m = 0;
    en = 1'b1; up = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      #1;
      total++; if (tc !== (m == 0)) begin bad++; $display("FAIL down_tc edge=%0d got=%b want=%b", i, tc, (m == 0)); end
      tick();
      total++; if (wrap !== (m == 0)) begin bad++; $display("FAIL down_wrap edge=%0d got=%b want=%b", i, wrap, (m == 0)); end
      m = (m == 0) ? 8 : m - 1;
      total++; if (q !== 4'(m)) begin bad++; $display("FAIL down_q edge=%0d got=%0d want=%0d", i, q, m); end
    end
  endtask

  // q is 8 here: up wraps to 0, then down wraps straight back to 8.
  task automatic test_direction_change();
    en = 1'b1; up = 1'b1; tick();
    total++; if (q !== 4'd0) begin bad++; $display("FAIL dir_up_q got=%0d want=0", q); end
    total++; if (wrap !== 1'b1) begin bad++; $display("FAIL dir_up_wrap got=%b want=1", wrap); end
    up = 1'b0; tick();
    total++; if (q !== 4'd8) begin bad++; $display("FAIL dir_down_q got=%0d want=8", q); end
    total++; if (wrap !== 1'b1) begin bad++; $display("FAIL dir_down_wrap got=%b want=1", wrap); end
    up = 1'b1; tick();
    total++; if (q !== 4'd0) begin bad++; $display("FAIL dir_up2_q got=%0d want=0", q); end
    up = 1'b0; tick();
    total++; if (q !== 4'd8) begin bad++; $display("FAIL dir_down2_q got=%0d want=8", q); end
  endtask

  task automatic test_hold();
    en = 1'b0; up = 1'b1;
    #1;
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL hold_tc got=%b want=0", tc); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (q !== 4'd8) begin bad++; $display("FAIL hold_q cyc=%0d got=%0d want=8", i, q); end
      total++; if (wrap !== 1'b0) begin bad++; $display("FAIL hold_wrap cyc=%0d got=%b want=0", i, wrap); end
    end
  endtask

  // q is 8, en/up would wrap, but clr wins over everything.
  task automatic test_clr_priority();
    en = 1'b1; up = 1'b1; clr = 1'b1;
`ifdef COUNTER_MODN_LOAD_EN
    load = 1'b1; din = 4'd3;
`endif
    #1;
    total++; if (tc !== 1'b1) begin bad++; $display("FAIL clr_tc_ungated got=%b want=1", tc); end
    tick();
    total++; if (q !== 4'd0) begin bad++; $display("FAIL clr_q got=%0d want=0", q); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL clr_wrap got=%b want=0", wrap); end
    clr = 1'b0; en = 1'b0;
`ifdef COUNTER_MODN_LOAD_EN
    load = 1'b0;
`endif
  endtask

`ifdef COUNTER_MODN_LOAD_EN
  task automatic test_load();
    en = 1'b0; load = 1'b1; din = 4'd5; tick();
    total++; if (q !== 4'd5) begin bad++; $display("FAIL load5_q got=%0d want=5", q); end
    din = 4'd12; tick();
    total++; if (q !== 4'd8) begin bad++; $display("FAIL load12_clamp got=%0d want=8", q); end
    din = 4'd4; tick();
    total++; if (q !== 4'd4) begin bad++; $display("FAIL load4_q got=%0d want=4", q); end
    din = 4'd15; tick();
    total++; if (q !== 4'd8) begin bad++; $display("FAIL load15_clamp got=%0d want=8", q); end
    en = 1'b1; up = 1'b1; din = 4'd8; tick();
    total++; if (q !== 4'd8) begin bad++; $display("FAIL load_over_en_q got=%0d want=8", q); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL load_over_en_wrap got=%b want=0", wrap); end
    load = 1'b0; en = 1'b0;
  endtask
`endif

  task automatic test_async_reset();
    clr = 1'b1; tick(); clr = 1'b0;
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    total++; if (q !== 4'd6) begin bad++; $display("FAIL areset_pre_q got=%0d want=6", q); end
    #2 rst = 1'b1;
    #1;
    total++; if (q !== 4'd0) begin bad++; $display("FAIL areset_q got=%0d want=0", q); end
    #1 rst = 1'b0;
    tick();
    total++; if (q !== 4'd1) begin bad++; $display("FAIL areset_resume_q got=%0d want=1", q); end
    for (int i = 0; i < 8; i++) tick();
    total++; if (q !== 4'd0) begin bad++; $display("FAIL areset_wrap_q got=%0d want=0", q); end
    total++; if (wrap !== 1'b1) begin bad++; $display("FAIL areset_wrap_pre got=%b want=1", wrap); end
    #2 rst = 1'b1;
    #1;
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL areset_wrap_cleared got=%b want=0", wrap); end
    #1 rst = 1'b0;
    en = 1'b0;
  endtask

  task automatic test_cascade();
    c_en = 1'b1; c_clr = 1'b1; tick(); c_clr = 1'b0;
    total++; if (lo_q !== 4'd0 || hi_q !== 2'd0) begin bad++; $display("FAIL casc_clr got=%0d/%0d want=0/0", hi_q, lo_q); end
    for (int i = 1; i <= 36; i++) begin
      tick();
      total++; if (lo_q !== 4'(i % 9)) begin bad++; $display("FAIL casc_lo_q edge=%0d got=%0d want=%0d", i, lo_q, i % 9); end
      total++; if (hi_q !== 2'((i / 9) % 4)) begin bad++; $display("FAIL casc_hi_q edge=%0d got=%0d want=%0d", i, hi_q, (i / 9) % 4); end
      total++; if (lo_wrap !== (i % 9 == 0)) begin bad++; $display("FAIL casc_lo_wrap edge=%0d got=%b want=%b", i, lo_wrap, (i % 9 == 0)); end
      total++; if (hi_wrap !== (i == 36)) begin bad++; $display("FAIL casc_hi_wrap edge=%0d got=%b want=%b", i, hi_wrap, (i == 36)); end
      total++; if (hi_tc !== ((i % 9 == 8) && ((i / 9) % 4 == 3))) begin bad++; $display("FAIL casc_hi_tc edge=%0d got=%b", i, hi_tc); end
    end
    c_en = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_count_up();
    test_count_down();
    test_direction_change();
    test_hold();
    test_clr_priority();
`ifdef COUNTER_MODN_LOAD_EN
    test_load();
`endif
    test_async_reset();
    test_cascade();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
